axis_mux_n_arb: RTL and testbench

- N-input AXI-Stream multiplexer with packet-aware arbitration and a registered output stage.
- Generalises the 2:1 stream mux in four ways: parametrised data width, parametrised channel count, selectable arbitration mode, and packet locking.
- Packet locking: once a channel is granted, it keeps the output until its beat with s_last is accepted. Packets are never interleaved.
- Placement: between multiple stream producers and a single downstream consumer in the datapath.

---
 rtl/axis_mux_n_arb.sv | 165 ++++++++++++++++
 tb/tb_axis_mux_n_arb.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_mux_n_arb.sv
// axis_mux_n_arb: N-input AXI-Stream mux with packet-locked arbitration and a
// registered master stage.
//
// Once a channel wins arbitration it owns the output until its s_last beat is
// accepted, so packets never interleave. Each arbitration costs exactly one
// bubble cycle spent in IDLE.
//
// Ports
//   clk, reset          rising-edge clock, async active-high reset
//   sel                 requested channel (ARB_MODE=1 only, looked at in IDLE)
//   s_data/s_valid/
//   s_ready/s_last      flattened slave channels, channel i at [i*DATA_W +: DATA_W]
//   m_data/m_valid/
//   m_last              registered master beat
//   m_ready             downstream ready
//   m_grant             channel that produced the beat on the master outputs
//   busy                high while a packet is locked

// Per-channel slice: ready gating plus an AND mask, so the top can build the
// data mux as a plain OR across channels.
module axis_mux_n_arb_lane #(
  parameter int DATA_W = 8
) (
  input  logic              hit,      // this channel holds the lock
  input  logic              free,     // master register can take a beat
  input  logic              s_valid,
  input  logic              s_last,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              acc,
  output logic [DATA_W-1:0] data_m,
  output logic              last_m
);
  assign s_ready = hit & free;
  assign acc     = s_valid & s_ready;
  assign data_m  = hit ? s_data : '0;
  assign last_m  = hit & s_last;
endmodule

module axis_mux_n_arb #(
  parameter int DATA_W   = 8,
  parameter int NUM_CH   = 4,
  parameter int ARB_MODE = 0,
  parameter int SEL_W    = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH*DATA_W-1:0] s_data,
  input  logic [NUM_CH-1:0]        s_valid,
  output logic [NUM_CH-1:0]        s_ready,
  input  logic [NUM_CH-1:0]        s_last,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic [SEL_W-1:0]         m_grant,
  output logic                     busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                        state, state_nxt;
  logic [SEL_W-1:0]              grant, grant_nxt;
  logic [SEL_W-1:0]              rr_last;
  logic [SEL_W-1:0]              rr_pick, cand, pick;
  logic                          rr_hit, ext_ok, pick_ok;
  logic                          locked, free, accept, beat_last;
  logic [DATA_W-1:0]             beat_data;
  logic [NUM_CH-1:0]             lane_hit, lane_acc, lane_last;
  logic [NUM_CH-1:0][DATA_W-1:0] lane_data;

  assign locked = (state == LOCKED);
  assign free   = !m_valid || m_ready;
  assign busy   = locked;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    assign lane_hit[g] = locked && (grant == SEL_W'(g));
    axis_mux_n_arb_lane #(.DATA_W(DATA_W)) u_lane (
      .hit     (lane_hit[g]),
      .free    (free),
      .s_valid (s_valid[g]),
      .s_last  (s_last[g]),
      .s_data  (s_data[g*DATA_W +: DATA_W]),
      .s_ready (s_ready[g]),
      .acc     (lane_acc[g]),
      .data_m  (lane_data[g]),
      .last_m  (lane_last[g])
    );
  end

  // Only the locked lane passes anything through its mask, so OR is the mux.
  always_comb begin
    beat_data = '0;
    for (int i = 0; i < NUM_CH; i++) beat_data |= lane_data[i];
  end
  assign accept    = |lane_acc;
  assign beat_last = |lane_last;

  // Round-robin: first valid channel after the last packet's owner.
  always_comb begin
    rr_hit  = 1'b0;
    rr_pick = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = SEL_W'((int'(rr_last) + k) % NUM_CH);
      if (!rr_hit && s_valid[cand]) begin
        rr_hit  = 1'b1;
        rr_pick = cand;
      end
    end
  end

  // External select: out-of-range indices never win.
  assign ext_ok  = (int'(sel) < NUM_CH) && s_valid[sel];
  assign pick_ok = (ARB_MODE == 1) ? ext_ok : rr_hit;
  assign pick    = (ARB_MODE == 1) ? sel : rr_pick;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        if (pick_ok) begin
          state_nxt = LOCKED;
          grant_nxt = pick;
        end
      end
      LOCKED: begin
        if (accept && beat_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= '0;
      rr_last <= SEL_W'(NUM_CH - 1);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (accept && beat_last) rr_last <= grant;
    end
  end

  // Master register: load on accept, otherwise drain on handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_grant <= '0;
    end else if (accept) begin
      m_valid <= 1'b1;
      m_data  <= beat_data;
      m_last  <= beat_last;
      m_grant <= grant;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_mux_n_arb.sv
module tb_axis_mux_n_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  sel = '0;
  logic [31:0] s_data = '0;
  logic [3:0]  s_valid = '0;
  logic [3:0]  s_last = '0;
  logic        m_ready = 1'b0;

  logic [3:0] r_sready;
  logic [7:0] r_mdata;
  logic       r_mvalid, r_mlast, r_busy;
  logic [1:0] r_mgrant;

  logic [2:0] e_sready;
  logic [7:0] e_mdata;
  logic       e_mvalid, e_mlast, e_busy;
  logic [1:0] e_mgrant;

  always #5 clk = ~clk;

  axis_mux_n_arb #(.DATA_W(8), .NUM_CH(4), .ARB_MODE(0)) u_rr (
    .clk(clk), .reset(reset), .sel(sel),
    .s_data(s_data), .s_valid(s_valid), .s_ready(r_sready), .s_last(s_last),
    .m_data(r_mdata), .m_valid(r_mvalid), .m_ready(m_ready), .m_last(r_mlast),
    .m_grant(r_mgrant), .busy(r_busy)
  );

  // Three channels so sel=3 is an out-of-range request.
  axis_mux_n_arb #(.DATA_W(8), .NUM_CH(3), .ARB_MODE(1)) u_ext (
    .clk(clk), .reset(reset), .sel(sel),
    .s_data(s_data[23:0]), .s_valid(s_valid[2:0]), .s_ready(e_sready), .s_last(s_last[2:0]),
    .m_data(e_mdata), .m_valid(e_mvalid), .m_ready(m_ready), .m_last(e_mlast),
    .m_grant(e_mgrant), .busy(e_busy)
  );

  int total = 0;
  int bad = 0;

  // Source beats per channel, consumed on handshake.
  int         src_n[4], src_p[4], src_start[4], last_hs[4];
  logic [7:0] src_d[4][64];
  logic       src_l[4][64];
  int         rdy_mode;
  logic [3:0] rdy_pat;
  logic [1:0] sel_a, sel_b;
  int         sel_sw;
  int         ncyc;

  logic [7:0] obs_d[$];
  logic       obs_l[$];
  logic [1:0] obs_g[$];
  int         obs_c[$];

  logic       h_mv[2048], h_mr[2048], h_busy[2048];
  logic [7:0] h_md[2048];
  logic [3:0] h_sr[2048];

  task automatic clear_src();
    for (int ch = 0; ch < 4; ch++) begin
      src_n[ch] = 0; src_p[ch] = 0; src_start[ch] = 0; last_hs[ch] = -1;
    end
    obs_d.delete(); obs_l.delete(); obs_g.delete(); obs_c.delete();
    rdy_mode = 0; rdy_pat = 4'hF; sel_a = 2'd0; sel_b = 2'd0; sel_sw = 0; ncyc = 0;
  endtask

  task automatic add_beat(input int ch, input logic [7:0] d, input logic l);
    src_d[ch][src_n[ch]] = d;
    src_l[ch][src_n[ch]] = l;
    src_n[ch]++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; s_valid = '0; s_last = '0; s_data = '0; m_ready = 1'b0; sel = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives the sources and downstream ready once per cycle and records what
  // the selected DUT presents; stops when nbeats master beats were taken.
  task automatic run(input bit ext, input int nbeats, input int budget, output bit timeout);
    logic       mv, ml;
    logic [7:0] md;
    logic [1:0] mg;
    logic [3:0] sr;
    timeout = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      for (int ch = 0; ch < 4; ch++) begin
        if (src_p[ch] < src_n[ch] && c >= src_start[ch]) begin
          s_valid[ch] = 1'b1;
          s_data[ch*8 +: 8] = src_d[ch][src_p[ch]];
          s_last[ch] = src_l[ch][src_p[ch]];
        end else begin
          s_valid[ch] = 1'b0;
          s_data[ch*8 +: 8] = 8'($urandom);
          s_last[ch] = 1'($urandom);
        end
      end
      if (rdy_mode == 0)      m_ready = 1'b1;
      else if (rdy_mode == 1) m_ready = 1'($urandom_range(0, 1));
      else                    m_ready = rdy_pat[c[1:0]];
      sel = (c < sel_sw) ? sel_a : sel_b;
      #1;
      if (ext) begin
        mv = e_mvalid; md = e_mdata; ml = e_mlast; mg = e_mgrant; sr = {1'b0, e_sready};
        h_busy[c] = e_busy;
      end else begin
        mv = r_mvalid; md = r_mdata; ml = r_mlast; mg = r_mgrant; sr = r_sready;
        h_busy[c] = r_busy;
      end
      h_mv[c] = mv; h_md[c] = md; h_mr[c] = m_ready; h_sr[c] = sr;
      if (mv && m_ready) begin
        obs_d.push_back(md); obs_l.push_back(ml); obs_g.push_back(mg); obs_c.push_back(c);
      end
      for (int ch = 0; ch < 4; ch++)
        if (s_valid[ch] && sr[ch]) begin
          if (s_last[ch]) last_hs[ch] = c;
          src_p[ch]++;
        end
      ncyc = c + 1;
      if (obs_d.size() == nbeats) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (r_mvalid !== 1'b0) begin bad++; $display("FAIL rst_mvalid got=%0b want=0", r_mvalid); end
    total++; if (r_mdata !== 8'h00) begin bad++; $display("FAIL rst_mdata got=%0h want=0", r_mdata); end
    total++; if (r_mlast !== 1'b0) begin bad++; $display("FAIL rst_mlast got=%0b want=0", r_mlast); end
    total++; if (r_mgrant !== 2'd0) begin bad++; $display("FAIL rst_mgrant got=%0d want=0", r_mgrant); end
    total++; if (r_sready !== 4'h0) begin bad++; $display("FAIL rst_sready got=%0h want=0", r_sready); end
    total++; if (r_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", r_busy); end
    total++; if (e_mvalid !== 1'b0) begin bad++; $display("FAIL rst_ext_mvalid got=%0b want=0", e_mvalid); end
    total++; if (e_sready !== 3'h0) begin bad++; $display("FAIL rst_ext_sready got=%0h want=0", e_sready); end
    total++; if (e_busy !== 1'b0) begin bad++; $display("FAIL rst_ext_busy got=%0b want=0", e_busy); end
  endtask

  // Every channel always valid with 2-beat packets: grants 0,0,1,1,2,2,3,3,0,0
  // and one bubble between packets.
  task automatic test_rr_2beat();
    bit to;
    logic [7:0] d;
    logic [1:0] g;
    do_reset(); clear_src();
    for (int ch = 0; ch < 4; ch++) begin
      d = 8'h10 + 8'(ch);
      add_beat(ch, d, 1'b0); add_beat(ch, d, 1'b1);
    end
    add_beat(0, 8'h10, 1'b0); add_beat(0, 8'h10, 1'b1);
    run(1'b0, 10, 200, to);
    total++; if (to) begin bad++; $display("FAIL rr2_timeout got=%0d beats want=10", obs_d.size()); end
    for (int i = 0; i < obs_d.size() && i < 10; i++) begin
      g = 2'((i / 2) % 4);
      d = 8'h10 + 8'(g);
      total++; if (obs_g[i] !== g) begin bad++; $display("FAIL rr2_grant[%0d] got=%0d want=%0d", i, obs_g[i], g); end
      total++; if (obs_d[i] !== d) begin bad++; $display("FAIL rr2_data[%0d] got=%0h want=%0h", i, obs_d[i], d); end
      total++; if (obs_l[i] !== 1'(i % 2)) begin bad++; $display("FAIL rr2_last[%0d] got=%0b want=%0b", i, obs_l[i], i % 2); end
    end
    // 5 in-packet steps of 1 cycle plus 4 packet boundaries of 2 cycles
    if (obs_c.size() == 10) begin
      total++; if (obs_c[9] - obs_c[0] !== 13) begin bad++; $display("FAIL rr2_span got=%0d want=13", obs_c[9] - obs_c[0]); end
    end
  endtask

  task automatic test_lock();
    bit to;
    int viol;
    logic [7:0] d;
    logic [1:0] g;
    do_reset(); clear_src();
    for (int i = 0; i < 4; i++) add_beat(1, 8'hA0 + 8'(i), i == 3);
    add_beat(2, 8'hB0, 1'b0); add_beat(2, 8'hB1, 1'b1);
    src_start[2] = 2;
    run(1'b0, 6, 200, to);
    total++; if (to) begin bad++; $display("FAIL lock_timeout got=%0d beats want=6", obs_d.size()); end
    for (int i = 0; i < obs_d.size() && i < 6; i++) begin
      g = (i < 4) ? 2'd1 : 2'd2;
      d = (i < 4) ? 8'hA0 + 8'(i) : 8'hB0 + 8'(i - 4);
      total++; if (obs_g[i] !== g) begin bad++; $display("FAIL lock_grant[%0d] got=%0d want=%0d", i, obs_g[i], g); end
      total++; if (obs_d[i] !== d) begin bad++; $display("FAIL lock_data[%0d] got=%0h want=%0h", i, obs_d[i], d); end
    end
    viol = 0;
    for (int c = 0; c <= last_hs[1] && c < ncyc; c++) if (h_sr[c][2]) viol++;
    total++; if (viol !== 0) begin bad++; $display("FAIL lock_sready2 got=%0d cycles high want=0", viol); end
  endtask

  task automatic test_backpressure();
    bit to;
    int stalls;
    logic [7:0] d;
    do_reset(); clear_src();
    add_beat(0, 8'h23, 1'b0); add_beat(0, 8'h24, 1'b0); add_beat(0, 8'h25, 1'b1);
    rdy_mode = 2; rdy_pat = 4'b1001;
    run(1'b0, 3, 200, to);
    total++; if (to) begin bad++; $display("FAIL bp_timeout got=%0d beats want=3", obs_d.size()); end
    for (int i = 0; i < obs_d.size() && i < 3; i++) begin
      d = 8'h23 + 8'(i);
      total++; if (obs_d[i] !== d) begin bad++; $display("FAIL bp_data[%0d] got=%0h want=%0h", i, obs_d[i], d); end
      total++; if (obs_l[i] !== (i == 2)) begin bad++; $display("FAIL bp_last[%0d] got=%0b want=%0b", i, obs_l[i], i == 2); end
    end
    stalls = 0;
    for (int c = 0; c < ncyc - 1; c++) begin
      if (h_mv[c] && !h_mr[c]) begin
        stalls++;
        total++; if (h_mv[c+1] !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d] got=%0b want=1", c, h_mv[c+1]); end
        total++; if (h_md[c+1] !== h_md[c]) begin bad++; $display("FAIL bp_hold_data[%0d] got=%0h want=%0h", c, h_md[c+1], h_md[c]); end
        total++; if (h_sr[c][0] !== 1'b0) begin bad++; $display("FAIL bp_sready[%0d] got=%0b want=0", c, h_sr[c][0]); end
      end
    end
    total++; if (stalls == 0) begin bad++; $display("FAIL bp_stalls got=%0d want>0", stalls); end
  endtask

  task automatic test_ext_sel();
    bit to;
    int bcnt;
    logic [7:0] d;
    logic [1:0] g;
    do_reset(); clear_src();
    add_beat(1, 8'h40, 1'b0); add_beat(1, 8'h41, 1'b0); add_beat(1, 8'h42, 1'b1);
    add_beat(0, 8'h30, 1'b0); add_beat(0, 8'h31, 1'b1);
    sel_a = 2'd1; sel_b = 2'd0; sel_sw = 2;
    run(1'b1, 5, 200, to);
    total++; if (to) begin bad++; $display("FAIL ext_timeout got=%0d beats want=5", obs_d.size()); end
    for (int i = 0; i < obs_d.size() && i < 5; i++) begin
      g = (i < 3) ? 2'd1 : 2'd0;
      d = (i < 3) ? 8'h40 + 8'(i) : 8'h30 + 8'(i - 3);
      total++; if (obs_g[i] !== g) begin bad++; $display("FAIL ext_grant[%0d] got=%0d want=%0d", i, obs_g[i], g); end
      total++; if (obs_d[i] !== d) begin bad++; $display("FAIL ext_data[%0d] got=%0h want=%0h", i, obs_d[i], d); end
    end
    // sel=3 is out of range for three channels: stay idle until sel=0.
    do_reset(); clear_src();
    add_beat(0, 8'h77, 1'b1);
    sel_a = 2'd3; sel_b = 2'd0; sel_sw = 6;
    run(1'b1, 1, 200, to);
    total++; if (to) begin bad++; $display("FAIL ext_oor_timeout got=%0d beats want=1", obs_d.size()); end
    bcnt = 0;
    for (int c = 0; c < 6 && c < ncyc; c++) if (h_busy[c]) bcnt++;
    total++; if (bcnt !== 0) begin bad++; $display("FAIL ext_oor_busy got=%0d cycles want=0", bcnt); end
    if (obs_d.size() == 1) begin
      total++; if (obs_c[0] !== 8) begin bad++; $display("FAIL ext_oor_cycle got=%0d want=8", obs_c[0]); end
      total++; if (obs_d[0] !== 8'h77) begin bad++; $display("FAIL ext_oor_data got=%0h want=77", obs_d[0]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_ready = 1'b1;
    @(negedge clk);
    s_valid = 4'b0100; s_last = 4'b0100; s_data = 32'h0066_0000;
    repeat (2) @(negedge clk);
    s_valid = 4'b1000; s_last = 4'b0000; s_data = 32'h5500_0000;
    repeat (2) @(negedge clk);
    #1;
    total++; if (r_busy !== 1'b1) begin bad++; $display("FAIL rm_busy_pre got=%0b want=1", r_busy); end
    total++; if (r_mgrant !== 2'd3) begin bad++; $display("FAIL rm_grant_pre got=%0d want=3", r_mgrant); end
    #2 reset = 1'b1;
    #1;
    total++; if (r_mvalid !== 1'b0) begin bad++; $display("FAIL rm_mvalid got=%0b want=0", r_mvalid); end
    total++; if (r_mdata !== 8'h00) begin bad++; $display("FAIL rm_mdata got=%0h want=0", r_mdata); end
    total++; if (r_mlast !== 1'b0) begin bad++; $display("FAIL rm_mlast got=%0b want=0", r_mlast); end
    total++; if (r_mgrant !== 2'd0) begin bad++; $display("FAIL rm_mgrant got=%0d want=0", r_mgrant); end
    total++; if (r_sready !== 4'h0) begin bad++; $display("FAIL rm_sready got=%0h want=0", r_sready); end
    total++; if (r_busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%0b want=0", r_busy); end
    @(negedge clk);
    reset = 1'b0;
    s_valid = 4'b1001; s_last = 4'b1001; s_data = 32'h0300_0001;
    repeat (2) @(negedge clk);
    #1;
    total++; if (r_mvalid !== 1'b1) begin bad++; $display("FAIL rm_next_valid got=%0b want=1", r_mvalid); end
    total++; if (r_mgrant !== 2'd0) begin bad++; $display("FAIL rm_next_grant got=%0d want=0", r_mgrant); end
    total++; if (r_mdata !== 8'h01) begin bad++; $display("FAIL rm_next_data got=%0h want=01", r_mdata); end
  endtask

  task automatic test_single_beat();
    bit to;
    logic [7:0] dexp[4];
    logic [1:0] gexp[4];
    do_reset(); clear_src();
    add_beat(0, 8'hC0, 1'b1); add_beat(0, 8'hC1, 1'b1);
    add_beat(2, 8'hE0, 1'b1); add_beat(2, 8'hE1, 1'b1);
    dexp = '{8'hC0, 8'hE0, 8'hC1, 8'hE1};
    gexp = '{2'd0, 2'd2, 2'd0, 2'd2};
    run(1'b0, 4, 200, to);
    total++; if (to) begin bad++; $display("FAIL sb_timeout got=%0d beats want=4", obs_d.size()); end
    for (int i = 0; i < obs_d.size() && i < 4; i++) begin
      total++; if (obs_g[i] !== gexp[i]) begin bad++; $display("FAIL sb_grant[%0d] got=%0d want=%0d", i, obs_g[i], gexp[i]); end
      total++; if (obs_d[i] !== dexp[i]) begin bad++; $display("FAIL sb_data[%0d] got=%0h want=%0h", i, obs_d[i], dexp[i]); end
      total++; if (obs_l[i] !== 1'b1) begin bad++; $display("FAIL sb_last[%0d] got=%0b want=1", i, obs_l[i]); end
    end
  endtask

  // Random packets on all channels with random backpressure. With every
  // channel continuously backlogged, round-robin order is simply channel
  // 0,1,2,3 per round, each packet delivered whole.
  task automatic test_random();
    bit to;
    int plen[4][4];
    int off, n;
    logic [7:0] ed[$];
    logic       el[$];
    logic [1:0] eg[$];
    do_reset(); clear_src();
    for (int ch = 0; ch < 4; ch++)
      for (int p = 0; p < 4; p++) begin
        plen[ch][p] = $urandom_range(1, 4);
        for (int b = 0; b < plen[ch][p]; b++) add_beat(ch, 8'($urandom), b == plen[ch][p] - 1);
      end
    for (int p = 0; p < 4; p++)
      for (int ch = 0; ch < 4; ch++) begin
        off = 0;
        for (int q = 0; q < p; q++) off += plen[ch][q];
        for (int b = 0; b < plen[ch][p]; b++) begin
          ed.push_back(src_d[ch][off + b]);
          el.push_back(b == plen[ch][p] - 1);
          eg.push_back(2'(ch));
        end
      end
    rdy_mode = 1;
    n = ed.size();
    run(1'b0, n, 1500, to);
    total++; if (to) begin bad++; $display("FAIL rnd_timeout got=%0d beats want=%0d", obs_d.size(), n); end
    for (int i = 0; i < obs_d.size() && i < n; i++) begin
      total++; if (obs_g[i] !== eg[i]) begin bad++; $display("FAIL rnd_grant[%0d] got=%0d want=%0d", i, obs_g[i], eg[i]); end
      total++; if (obs_d[i] !== ed[i]) begin bad++; $display("FAIL rnd_data[%0d] got=%0h want=%0h", i, obs_d[i], ed[i]); end
      total++; if (obs_l[i] !== el[i]) begin bad++; $display("FAIL rnd_last[%0d] got=%0b want=%0b", i, obs_l[i], el[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_rr_2beat();
    test_lock();
    test_backpressure();
    test_ext_sel();
    test_reset_mid();
    test_single_beat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
